led_display_mux: RTL and testbench
==================================

Name: led_display_mux

Overview:
- Multi-channel, multi-mode successor to the single-slice LED display.
- Selects one of NUM_CH packed data words and refreshes the board LEDs on a run-time-programmable update tick.
- Display modes: raw MSB slice, signed-magnitude bar graph, bar graph with decaying peak-hold marker, or blank.
- Sits between the datapath debug taps and the top-level LED pins.

Parameters:
- LED_BITS, 16, number of LEDs driven.
- DATA_BITS, 24, width of each channel word; two's complement in bar/peak modes; must be > LED_BITS.
- NUM_CH, 2, number of input channels.
- CH_SEL_BITS, 1, width of ch_sel; must satisfy 2**CH_SEL_BITS >= NUM_CH.
- PERIOD_BITS, 28, width of the update prescaler and of the period port.
- PEAK_HOLD_TICKS, 4, ticks the peak marker is held before decay starts; width 8 bits, 0 allowed.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- data_in  in  NUM_CH*DATA_BITS  packed channels; channel k at [k*DATA_BITS +: DATA_BITS].
- ch_sel  in  CH_SEL_BITS  channel to display.
- mode  in  2  0=RAW, 1=BAR, 2=PEAK, 3=BLANK.
- period  in  PERIOD_BITS  update interval minus one, in clk cycles.
- freeze  in  1  hold the displayed value and peak state.
- leds  out  LED_BITS  LED drive, registered.
- tick  out  1  one-cycle pulse marking an update edge, registered.

Behaviour:
- Reset: the following take these values on the first edge with rst=1, and hold them while rst=1:
  - count=0, tick=0, leds=0, peak=0, hold=0.
  - rst has priority over every other input.
- Prescaler:
  - count increments by 1 each cycle.
  - At an edge where count >= period: count<=0, tick<=1, update event fires.
  - Otherwise tick<=0.
  - period=0 gives a tick every cycle.
  - If period is lowered below the current count, the update fires on the next edge.
  - After rst drops with constant period P, the first update occurs at the edge ending cycle P; updates then repeat every P+1 cycles.
- Update event: leds, peak and hold load on the same edge tick goes high.
  - Inputs are sampled at that edge, so new leds are visible while tick=1.
  - Between updates, all state holds.
- freeze=1 at an update edge: tick still pulses; leds, peak and hold are unchanged.
- Channel select: sample = channel ch_sel; ch_sel >= NUM_CH selects channel 0.
- Magnitude:
  - mag = |sample|, DATA_BITS-1 bits.
  - The most negative value saturates to 2**(DATA_BITS-1)-1.
- Level:
  - level = ceil(mag*LED_BITS / 2**(DATA_BITS-1)), range 0..LED_BITS.
  - Exactly 0 only when mag=0.
  - Integer-only computation: (mag*LED_BITS + 2**(DATA_BITS-1)-1) >> (DATA_BITS-1), sized to avoid overflow.
- bar: bit i = 1 iff i < level (thermometer from bit 0).
- Peak tracking: runs on every non-frozen update, in all modes, so entering PEAK mode shows live history. Next-state rules:
  - If level > peak: peak<=level, hold<=PEAK_HOLD_TICKS.
  - Else if hold > 0: hold<=hold-1.
  - Else if peak > 0: peak<=peak-1.
  - Otherwise no change.
- marker = (peak_next > 0) ? 1 << (peak_next-1) : 0, using the next-state peak.
- leds on update, by mode:
  - RAW: sample[DATA_BITS-1 -: LED_BITS].
  - BAR: bar.
  - PEAK: bar | marker.
  - BLANK: 0.
- A mode or ch_sel change takes effect at the next update edge only.

Test Plan:
1. RAW, period=3, ch0=0xABCDEF, mode=0 after reset.
   - tick at cycles 3, 7, 11.
   - leds=0xABCD from cycle 4; leds=0 before.
2. BAR, ch0 values 0x400000, 0xC00000, 0x000001, 0x800000, 0x000000, one per tick.
   - leds = 0x00FF, 0x00FF, 0x0001, 0xFFFF, 0x0000.
3. PEAK, PEAK_HOLD_TICKS=2, period=0, ch0=0x400000 for one tick, then 0.
   - leds per tick: 0x00FF, 0x0080, 0x0080, 0x0040, 0x0020, and so on.
   - Reaches 0x0000 after peak decays to 0.
4. NUM_CH=3, CH_SEL_BITS=2, ch1=0x123456, ch0=0xFEDCBA.
   - ch_sel=1 gives leds=0x1234; ch_sel=3 gives 0xFEDC.
   - freeze=1 across 3 ticks: leds stay 0xFEDC while data changes; tick keeps pulsing.
5. period=100; at count=50 set period=10.
   - tick asserts on the next edge, count restarts at 0, subsequent ticks every 11 cycles.
6. rst asserted mid-PEAK-decay with leds=0x0040.
   - On the next edge: leds=0, tick=0, peak=0, count=0.
   - First post-reset update obeys the P+1 timing.

Source files
------------

// File: rtl/led_display_mux.sv
// ============================================================================
// led_display_mux : multi-channel LED display (raw / bar / peak-hold / blank)
// Rev 1.0
// ============================================================================
`default_nettype none

module led_display_mux #(
  parameter int LED_BITS        = 16,
  parameter int DATA_BITS       = 24,
  parameter int NUM_CH          = 2,
  parameter int CH_SEL_BITS     = 1,
  parameter int PERIOD_BITS     = 28,
  parameter int PEAK_HOLD_TICKS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH*DATA_BITS-1:0] data_in,
  input  logic [CH_SEL_BITS-1:0]      ch_sel,
  input  logic [1:0]                  mode,
  input  logic [PERIOD_BITS-1:0]      period,
  input  logic                        freeze,
  output logic [LED_BITS-1:0]         leds,
  output logic                        tick
);

  localparam int c_LVL_W  = $clog2(LED_BITS + 1);
  localparam int c_PROD_W = DATA_BITS + $clog2(LED_BITS + 1);
  localparam logic [c_PROD_W-1:0] c_ROUND =
      (c_PROD_W'(1) << (DATA_BITS - 1)) - c_PROD_W'(1);
  localparam logic [7:0] c_HOLD_INIT = 8'(PEAK_HOLD_TICKS);

  localparam logic [1:0] c_MODE_RAW   = 2'd0;
  localparam logic [1:0] c_MODE_BAR   = 2'd1;
  localparam logic [1:0] c_MODE_PEAK  = 2'd2;
  localparam logic [1:0] c_MODE_BLANK = 2'd3;

  logic [PERIOD_BITS-1:0] r_count;
  logic                   r_tick;
  logic [LED_BITS-1:0]    r_leds;
  logic [c_LVL_W-1:0]     r_peak;
  logic [7:0]             r_hold;

  logic [DATA_BITS-1:0]   w_sample;
  logic [DATA_BITS-2:0]   w_neg;
  logic [DATA_BITS-2:0]   w_mag;
  logic [c_PROD_W-1:0]    w_prod;
  logic [c_LVL_W-1:0]     w_level;
  logic [LED_BITS-1:0]    w_bar;
  logic [LED_BITS-1:0]    w_marker;
  logic [c_LVL_W-1:0]     w_peak_next;
  logic [7:0]             w_hold_next;
  logic [LED_BITS-1:0]    w_leds_next;
  logic                   w_update;

  // Out-of-range selects fall back to channel 0.
  always_comb begin
    w_sample = data_in[0 +: DATA_BITS];
    for (int k = 1; k < NUM_CH; k++) begin
      if (ch_sel == CH_SEL_BITS'(k)) begin
        w_sample = data_in[k*DATA_BITS +: DATA_BITS];
      end
    end
  end

  // Only the low bits of the negation are needed; the most negative value
  // has no positive counterpart and saturates.
  always_comb begin
    w_neg = ~w_sample[DATA_BITS-2:0] + (DATA_BITS-1)'(1);
    if (!w_sample[DATA_BITS-1]) begin
      w_mag = w_sample[DATA_BITS-2:0];
    end else if (w_sample[DATA_BITS-2:0] == '0) begin
      w_mag = '1;
    end else begin
      w_mag = w_neg;
    end
  end

  always_comb begin
    w_prod  = c_PROD_W'(w_mag) * c_PROD_W'(LED_BITS) + c_ROUND;
    w_level = c_LVL_W'(w_prod >> (DATA_BITS - 1));
  end

  always_comb begin
    w_peak_next = r_peak;
    w_hold_next = r_hold;
    if (w_level > r_peak) begin
      w_peak_next = w_level;
      w_hold_next = c_HOLD_INIT;
    end else if (r_hold != 8'd0) begin
      w_hold_next = r_hold - 8'd1;
    end else if (r_peak != '0) begin
      w_peak_next = r_peak - c_LVL_W'(1);
    end
  end

  always_comb begin
    w_bar    = '0;
    w_marker = '0;
    for (int i = 0; i < LED_BITS; i++) begin
      w_bar[i]    = (c_LVL_W'(i) < w_level);
      w_marker[i] = (w_peak_next == c_LVL_W'(i + 1));
    end
  end

  always_comb begin
    w_leds_next = '0;
    case (mode)
      c_MODE_RAW:   w_leds_next = w_sample[DATA_BITS-1 -: LED_BITS];
      c_MODE_BAR:   w_leds_next = w_bar;
      c_MODE_PEAK:  w_leds_next = w_bar | w_marker;
      c_MODE_BLANK: w_leds_next = '0;
      default:      w_leds_next = '0;
    endcase
  end

  assign w_update = (r_count >= period);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_tick  <= 1'b0;
      r_leds  <= '0;
      r_peak  <= '0;
      r_hold  <= 8'd0;
    end else if (w_update) begin
      r_count <= '0;
      r_tick  <= 1'b1;
      if (!freeze) begin
        r_leds <= w_leds_next;
        r_peak <= w_peak_next;
        r_hold <= w_hold_next;
      end
    end else begin
      r_count <= r_count + PERIOD_BITS'(1);
      r_tick  <= 1'b0;
    end
  end

  assign leds = r_leds;
  assign tick = r_tick;

endmodule

`default_nettype wire

// File: tb/tb_led_display_mux.sv
// Self-checking bench for led_display_mux: directed scenarios plus random traffic.
`default_nettype none

module tb_led_display_mux;

  localparam int LB  = 16;
  localparam int DB  = 24;
  localparam int NC  = 3;
  localparam int CSB = 2;
  localparam int PB  = 28;
  localparam int PHT = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NC*DB-1:0]  data_in;
  logic [CSB-1:0]    ch_sel;
  logic [1:0]        mode;
  logic [PB-1:0]     period;
  logic              freeze;
  logic [LB-1:0]     leds;
  logic              tick;

  int checks = 0;
  int errors = 0;

  int          m_count;
  int          m_peak;
  int          m_hold;
  logic [15:0] m_leds;
  logic        m_tick;

  led_display_mux #(
    .LED_BITS(LB), .DATA_BITS(DB), .NUM_CH(NC), .CH_SEL_BITS(CSB),
    .PERIOD_BITS(PB), .PEAK_HOLD_TICKS(PHT)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .ch_sel(ch_sel), .mode(mode),
    .period(period), .freeze(freeze), .leds(leds), .tick(tick)
  );

  always #5 clk = ~clk;

  function automatic int level_of(logic [DB-1:0] s);
    longint v, mag, lim;
    lim = (longint'(1) << (DB - 1)) - 1;
    v   = longint'($signed(s));
    mag = (v < 0) ? -v : v;
    if (mag > lim) mag = lim;
    return int'((mag * LB + lim) >> (DB - 1));
  endfunction

  // Reference: state advances with arithmetic on plain integers.
  task automatic model_edge();
    int idx, lvl, bar, marker;
    logic [DB-1:0] s;
    if (rst) begin
      m_count = 0; m_tick = 1'b0; m_leds = '0; m_peak = 0; m_hold = 0;
    end else if (m_count >= int'(period)) begin
      m_count = 0;
      m_tick  = 1'b1;
      if (!freeze) begin
        idx = (int'(ch_sel) < NC) ? int'(ch_sel) : 0;
        s   = data_in[idx*DB +: DB];
        lvl = level_of(s);
        if (lvl > m_peak) begin
          m_peak = lvl; m_hold = PHT;
        end else if (m_hold > 0) begin
          m_hold--;
        end else if (m_peak > 0) begin
          m_peak--;
        end
        bar    = (1 << lvl) - 1;
        marker = (m_peak > 0) ? (1 << (m_peak - 1)) : 0;
        case (mode)
          2'd0:    m_leds = s[DB-1 -: 16];
          2'd1:    m_leds = 16'(bar);
          2'd2:    m_leds = 16'(bar | marker);
          default: m_leds = 16'h0000;
        endcase
      end
    end else begin
      m_count++;
      m_tick = 1'b0;
    end
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    chk("leds", 32'(leds), 32'(m_leds));
    chk("tick", 32'(tick), 32'(m_tick));
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!m_tick && n < 500);
    chk("tick_wait", 32'(tick), 32'd1);
  endtask

  function automatic logic [DB-1:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 24'h800000;
      1:       return 24'h000000;
      2:       return 24'h7FFFFF;
      3:       return 24'(($urandom_range(0, 1) == 1) ? 1 : -1);
      default: return 24'($urandom);
    endcase
  endfunction

  logic [15:0] bar_exp [5] = '{16'h00FF, 16'h00FF, 16'h0001, 16'hFFFF, 16'h0000};
  logic [23:0] bar_in  [5] = '{24'h400000, 24'hC00000, 24'h000001, 24'h800000, 24'h000000};
  logic [15:0] pk_exp  [10] = '{16'h0080, 16'h0080, 16'h0040, 16'h0020, 16'h0010,
                                16'h0008, 16'h0004, 16'h0002, 16'h0001, 16'h0000};

  initial begin
    int n;
    rst = 1'b1; data_in = '0; ch_sel = '0; mode = 2'd0; period = PB'(3); freeze = 1'b0;
    m_count = 0; m_tick = 1'b0; m_leds = '0; m_peak = 0; m_hold = 0;
    repeat (3) cycle();
    chk("reset_leds", 32'(leds), 32'h0);

    // Raw slice, period 3
    rst = 1'b0;
    data_in[23:0] = 24'hABCDEF;
    wait_tick(n);
    chk("raw_first_latency", 32'(n), 32'd4);
    chk("raw_leds", 32'(leds), 32'hABCD);
    wait_tick(n);
    chk("raw_period", 32'(n), 32'd4);

    // Bar graph
    mode = 2'd1;
    for (int i = 0; i < 5; i++) begin
      data_in[23:0] = bar_in[i];
      wait_tick(n);
      chk("bar_leds", 32'(leds), 32'(bar_exp[i]));
    end

    // Peak hold and decay, period 0
    rst = 1'b1; period = '0; cycle();
    rst = 1'b0; mode = 2'd2; data_in[23:0] = 24'h400000;
    cycle();
    chk("peak_first", 32'(leds), 32'h00FF);
    data_in[23:0] = 24'h0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("peak_decay", 32'(leds), 32'(pk_exp[i]));
    end

    // Reset mid-decay
    data_in[23:0] = 24'h400000; cycle();
    data_in[23:0] = 24'h0; repeat (3) cycle();
    chk("pre_rst_leds", 32'(leds), 32'h0040);
    rst = 1'b1; period = PB'(3); cycle();
    chk("rst_leds", 32'(leds), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    rst = 1'b0;
    wait_tick(n);
    chk("post_rst_latency", 32'(n), 32'd4);
    chk("post_rst_peak", 32'(leds), 32'h0);

    // Channel select and freeze
    mode = 2'd0;
    data_in[47:24] = 24'h123456; data_in[23:0] = 24'hFEDCBA;
    ch_sel = 2'd1;
    wait_tick(n);
    chk("ch1", 32'(leds), 32'h1234);
    ch_sel = 2'd3;
    wait_tick(n);
    chk("ch_oob", 32'(leds), 32'hFEDC);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = {rand_word(), rand_word(), rand_word()};
      wait_tick(n);
      chk("freeze_leds", 32'(leds), 32'hFEDC);
      chk("freeze_interval", 32'(n), 32'd4);
    end
    freeze = 1'b0;

    // Period lowered below current count
    rst = 1'b1; period = PB'(100); cycle();
    rst = 1'b0;
    repeat (50) cycle();
    period = PB'(10);
    cycle();
    chk("period_drop_tick", 32'(tick), 32'd1);
    wait_tick(n);
    chk("period_drop_int1", 32'(n), 32'd11);
    wait_tick(n);
    chk("period_drop_int2", 32'(n), 32'd11);

    // Random traffic against the model
    period = PB'(1);
    for (int i = 0; i < 600; i++) begin
      data_in = {rand_word(), rand_word(), rand_word()};
      if ($urandom_range(0, 3) == 0) ch_sel = CSB'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      freeze = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 31) == 0) period = PB'($urandom_range(0, 5));
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
